// File: rtl/mux16_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux16_scan_ctrl
// Brief    : Scan sequencer for a 16:1 mux. Steps the mux select through the
//            enabled channels in ascending order, waits SETTLE_CYC clocks on
//            each, samples the mux output and publishes the 16-bit result with
//            a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_scan_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] mask_i,
  input  logic        mux_out_i,
  output logic [3:0]  sel_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] data_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The counter only ever holds SETTLE_CYC-1 down to 0.
  localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
  // With no settle time a freshly selected channel is sampled on the next clock.
  localparam state_t          ST_AFTER_SEL = (SETTLE_CYC > 0) ? ST_SETTLE : ST_SAMPLE;

  state_t             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        mask_q, mask_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [15:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               first_vld;
  logic [3:0]         first_ch;
  logic               next_vld;
  logic [3:0]         next_ch;
  logic [15:0]        shadow_smp;

  // Lowest enabled channel of the incoming mask and next enabled channel above sel.
  always_comb begin
    first_vld = 1'b0;
    first_ch  = 4'd0;
    next_vld  = 1'b0;
    next_ch   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_vld = 1'b1;
        first_ch  = 4'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_vld = 1'b1;
        next_ch  = 4'(i);
      end
    end
  end

  // Shadow word with the current mux sample merged in at the selected position.
  always_comb begin
    shadow_smp         = shadow_q;
    shadow_smp[sel_q]  = mux_out_i;
  end

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    unique case (state_q)
      ST_IDLE: begin
        sel_d = 4'd0;
        if (start_i) begin
          mask_d   = mask_i;
          shadow_d = 16'd0;
          if (!first_vld) begin
            // Empty scan: the cleared shadow is published immediately.
            state_d = ST_DONE;
            data_d  = 16'd0;
          end else begin
            sel_d   = first_ch;
            cnt_d   = CNT_LOAD;
            state_d = ST_AFTER_SEL;
          end
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sel_d   = 4'd0;
        end else if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          sel_d   = 4'd0;
        end else begin
          shadow_d = shadow_smp;
          if (next_vld) begin
            sel_d   = next_ch;
            cnt_d   = CNT_LOAD;
            state_d = ST_AFTER_SEL;
          end else begin
            state_d = ST_DONE;
            data_d  = shadow_smp;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset discards any partial scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 4'd0;
      cnt_q    <= '0;
      mask_q   <= 16'd0;
      shadow_q <= 16'd0;
      data_q   <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel_o  = sel_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_scan_ctrl
// Brief    : Directed bench for mux16_scan_ctrl. Two instances (settle 1 and
//            settle 0) share stimulus; one of them is observed per scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_scan_ctrl;

  typedef struct {
    logic        dut0;       // observe the SETTLE_CYC=0 instance
    logic [15:0] mask;
    logic [15:0] in_w;
    logic [15:0] exp_data;
    int          exp_lat;    // clocks from accepting edge to done
    int          restart_at; // cycle index of an extra start pulse, -1 none
    logic        abt;        // abort raised together with start
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [15:0] mask_i;
  logic [15:0] in_w;
  logic        use0;

  logic [3:0]  sel1, sel0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] data1, data0;
  logic        mux1, mux0;

  logic [3:0]  sel_m;
  logic        busy_m, done_m;
  logic [15:0] data_m;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_data;

  vec_t vecs [10];

  always #5 clk = ~clk;

  // Mux model: output bit is the input word indexed by the select.
  assign mux1 = in_w[sel1];
  assign mux0 = in_w[sel0];

  assign sel_m  = use0 ? sel0  : sel1;
  assign busy_m = use0 ? busy0 : busy1;
  assign done_m = use0 ? done0 : done1;
  assign data_m = use0 ? data0 : data1;

  mux16_scan_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mask_i    (mask_i),
    .mux_out_i (mux1),
    .sel_o     (sel1),
    .busy_o    (busy1),
    .done_o    (done1),
    .data_o    (data1)
  );

  mux16_scan_ctrl #(.SETTLE_CYC(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mask_i    (mask_i),
    .mux_out_i (mux0),
    .sel_o     (sel0),
    .busy_o    (busy0),
    .done_o    (done0),
    .data_o    (data0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One scan: accept, then observe a fixed 40-cycle window.
  task automatic do_scan(input vec_t v, input int idx);
    int          lat;
    int          ndone;
    int          busy_cnt;
    logic [15:0] vis;
    logic [15:0] got_data;
    bit          order_ok;
    bit          stable_ok;
    int          prev_sel;
    string       tag;
    tag       = $sformatf("v%0d", idx);
    lat       = -1;
    ndone     = 0;
    busy_cnt  = 0;
    vis       = 16'd0;
    got_data  = 16'hxxxx;
    order_ok  = 1'b1;
    stable_ok = 1'b1;
    prev_sel  = -1;
    use0      = v.dut0;
    @(negedge clk);
    mask_i  = v.mask;
    in_w    = v.in_w;
    start_i = 1'b1;
    abort_i = v.abt;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    mask_i  = ~v.mask;
    for (int k = 0; k < 40; k++) begin
      if (busy_m) begin
        busy_cnt++;
        vis = vis | (16'd1 << sel_m);
        if (int'(sel_m) < prev_sel || !v.mask[sel_m]) order_ok = 1'b0;
        prev_sel = int'(sel_m);
      end
      if (done_m) begin
        ndone++;
        if (lat < 0) begin
          lat      = k;
          got_data = data_m;
        end
      end else if (lat < 0 && data_m !== last_data) begin
        stable_ok = 1'b0;
      end
      start_i = (k == v.restart_at);
      @(posedge clk);
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " data"}, {16'd0, got_data}, {16'd0, v.exp_data});
    check({tag, " done_count"}, ndone, 1);
    check({tag, " visited"}, {16'd0, vis}, {16'd0, v.mask});
    check({tag, " busy_cycles"}, busy_cnt, v.exp_lat);
    check({tag, " sel_order"}, {31'd0, order_ok}, 32'd1);
    check({tag, " data_stable"}, {31'd0, stable_ok}, 32'd1);
    last_data = v.exp_data;
  endtask

  initial begin
    int  ndone;
    bit  found;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    mask_i    = 16'd0;
    in_w      = 16'd0;
    use0      = 1'b0;
    last_data = 16'd0;

    //            dut0  mask      in        exp_data  lat restart abt
    vecs[0] = '{1'b0, 16'hFFFF, 16'hA5C3, 16'hA5C3, 32, -1, 1'b0};
    vecs[1] = '{1'b0, 16'h8101, 16'hFFFF, 16'h8101,  6, -1, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000,  0, -1, 1'b0};
    vecs[3] = '{1'b0, 16'h00F0, 16'h0F50, 16'h0050,  8, -1, 1'b0};
    vecs[4] = '{1'b0, 16'h0001, 16'h0001, 16'h0001,  2, -1, 1'b0};
    vecs[5] = '{1'b0, 16'h8000, 16'h7FFF, 16'h0000,  2, -1, 1'b0};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h1234, 16'h1234, 16,  5, 1'b0};
    vecs[7] = '{1'b1, 16'h0421, 16'hFFFF, 16'h0421,  3, -1, 1'b0};
    vecs[8] = '{1'b0, 16'hFFFF, 16'hA5C3, 16'hA5C3, 32, 10, 1'b0};
    vecs[9] = '{1'b0, 16'h0003, 16'h0002, 16'h0002,  4, -1, 1'b1};

    // Reset values
    #1;
    check("rst_sel",  {28'd0, sel1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_data", {16'd0, data1}, 32'd0);
    check("rst_data0", {16'd0, data0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_scan(vecs[i], i);
    end

    // Abort while sel=5 during a full scan: no done, data retained
    use0 = 1'b0;
    @(negedge clk);
    mask_i  = 16'hFFFF;
    in_w    = 16'h5A5A;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (sel_m == 4'd5) begin
        found   = 1'b1;
        abort_i = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    abort_i = 1'b0;
    check("abort_reached", {31'd0, found}, 32'd1);
    check("abort_busy", {31'd0, busy_m}, 32'd0);
    check("abort_sel",  {28'd0, sel_m}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_m) ndone++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_data", {16'd0, data_m}, {16'd0, last_data});

    // Asynchronous reset mid-scan clears outputs without a clock edge
    @(negedge clk);
    mask_i  = 16'hFFFF;
    in_w    = 16'hFFFF;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_m}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sel",  {28'd0, sel_m}, 32'd0);
    check("arst_busy", {31'd0, busy_m}, 32'd0);
    check("arst_done", {31'd0, done_m}, 32'd0);
    check("arst_data", {16'd0, data_m}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy_m}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
